// File: rtl/cdc_pkg.sv
// Shared state type and elaboration helpers for the clka-side pulse scheduler.
package cdc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HI = 2'd1,
        WAIT_LO = 2'd2
    } sched_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Legal parameter set: ID_W sized exactly for N_REQ, counter wide enough for TO_CYC.
    function automatic bit params_ok(input int n_req, input int id_w,
                                     input int to_cyc, input int to_w);
        return (n_req >= 2) && (n_req <= 16) && (id_w == clog2(n_req)) &&
               (to_cyc >= 1) && (to_cyc <= 65535) && ((1 << to_w) > to_cyc);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: grants the first set request at or after ptr, wrapping mod N.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the grant is a pure function of req and ptr.
module rr_arbiter
    import cdc_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any_vld
);

    int            k;
    logic [IW-1:0] kk;
    logic          found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        kk    = '0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr) + i;
            if (k >= N) k = k - N;
            kk = IW'(k);
            if (!found && req[kk]) begin
                found     = 1'b1;
                grant[kk] = 1'b1;
                idx       = kk;
            end
        end
    end

    assign any_vld = |req;

endmodule

// File: rtl/cdc_pulse_sched.sv
// Shares one toggle/level pulse synchronizer among N_REQ requesters, round-robin, one handshake at a time.
// Latency: request pulse to sync_pulse_o is 2 cycles when idle and ack is low.
// Backpressure: requests are held as sticky pending bits while a handshake is outstanding; extras merge and flag ovf_o.
module cdc_pulse_sched
    import cdc_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ID_W   = 2,
    parameter int TO_CYC = 255,
    parameter int TO_W   = 8
) (
    input  logic             clka,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] ovf_o,
    output logic             sync_pulse_o,
    output logic [ID_W-1:0]  sync_id_o,
    input  logic             sync_ack_i,
    output logic             busy_o,
    output logic             timeout_o,
    output logic [N_REQ-1:0] pend_o
);

    if (!params_ok(N_REQ, ID_W, TO_CYC, TO_W)) begin : g_param_chk
        $error("cdc_pulse_sched: illegal N_REQ/ID_W/TO_CYC/TO_W combination");
    end

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

    sched_state_t     state, state_nxt;
    logic [N_REQ-1:0] pend, grant, clr;
    logic [ID_W-1:0]  ptr, win_idx;
    logic [TO_W-1:0]  cnt;
    logic             any_pend, issue, to_hit, timeout_nxt;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (ID_W)
    ) u_arb (
        .req     (pend),
        .ptr     (ptr),
        .grant   (grant),
        .idx     (win_idx),
        .any_vld (any_pend)
    );

    // The counter spans both wait phases, so one budget covers the whole round trip.
    assign to_hit = (cnt >= TO_LAST);

    always_comb begin
        state_nxt   = state;
        issue       = 1'b0;
        timeout_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                // A high ack here is stale (post-reset or post-timeout); wait for it to fall.
                if (any_pend && !sync_ack_i) begin
                    issue     = 1'b1;
                    state_nxt = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (sync_ack_i) begin
                    state_nxt = WAIT_LO;
                end else if (to_hit) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            WAIT_LO: begin
                if (!sync_ack_i) begin
                    state_nxt = IDLE;
                end else if (to_hit) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign clr = issue ? grant : '0;

    always_ff @(posedge clka) begin
        if (rst) begin
            state        <= IDLE;
            pend         <= '0;
            ptr          <= '0;
            cnt          <= '0;
            ovf_o        <= '0;
            sync_pulse_o <= 1'b0;
            sync_id_o    <= '0;
            busy_o       <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            state        <= state_nxt;
            pend         <= (pend & ~clr) | req_i;
            ovf_o        <= req_i & pend & ~clr;
            sync_pulse_o <= issue;
            timeout_o    <= timeout_nxt;
            busy_o       <= (state_nxt != IDLE);
            if (issue) begin
                sync_id_o <= win_idx;
                ptr       <= (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + ID_W'(1);
                cnt       <= '0;
            end else if (state != IDLE) begin
                cnt <= cnt + TO_W'(1);
            end
        end
    end

    assign pend_o = pend;

endmodule

// File: tb/tb_cdc_pulse_sched.sv
// Self-checking bench for cdc_pulse_sched: directed scenarios plus a randomized run against a pending-set model.
module tb_cdc_pulse_sched;

    localparam int N    = 4;
    localparam int IW   = 2;
    localparam int TO   = 16;
    localparam int MAXC = 4096;

    logic          clka = 1'b0;
    logic          rst  = 1'b1;
    logic [N-1:0]  req_i = '0;
    logic [N-1:0]  ovf_o, pend_o;
    logic          sync_pulse_o, busy_o, timeout_o, sync_ack_i;
    logic [IW-1:0] sync_id_o;

    cdc_pulse_sched #(.N_REQ(N), .ID_W(IW), .TO_CYC(TO), .TO_W(8)) dut (
        .clka         (clka),
        .rst          (rst),
        .req_i        (req_i),
        .ovf_o        (ovf_o),
        .sync_pulse_o (sync_pulse_o),
        .sync_id_o    (sync_id_o),
        .sync_ack_i   (sync_ack_i),
        .busy_o       (busy_o),
        .timeout_o    (timeout_o),
        .pend_o       (pend_o)
    );

    initial forever #5 clka = ~clka;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Per-edge log: inputs sampled at the edge, registered outputs seen after it.
    logic [N-1:0]  req_log [MAXC];
    logic [N-1:0]  ovf_log [MAXC];
    logic [N-1:0]  pend_log[MAXC];
    logic [IW-1:0] id_log  [MAXC];
    logic          pulse_log[MAXC], ack_log[MAXC], busy_log[MAXC], to_log[MAXC];
    logic [N-1:0]  req_s;
    logic          ack_s;

    initial forever begin
        @(posedge clka);
        cyc++;
        req_s = req_i;
        ack_s = sync_ack_i;
        @(negedge clka);
        if (cyc < MAXC) begin
            req_log[cyc]   = req_s;
            ack_log[cyc]   = ack_s;
            ovf_log[cyc]   = ovf_o;
            pend_log[cyc]  = pend_o;
            id_log[cyc]    = sync_id_o;
            pulse_log[cyc] = sync_pulse_o;
            busy_log[cyc]  = busy_o;
            to_log[cyc]    = timeout_o;
        end
    end

    // Far-side responder: raises ack cur_hi cycles after a pulse, drops it cur_lo cycles later.
    bit   rsp_auto = 1'b0;
    bit   rsp_rand = 1'b0;
    int   hi_dly = 6, lo_dly = 6, cur_hi = 6, cur_lo = 6;
    int   rsp_ph = 0, rsp_cnt = 0;
    logic ack_auto = 1'b0;
    logic ack_man  = 1'b0;
    assign sync_ack_i = rsp_auto ? ack_auto : ack_man;

    initial forever begin
        @(posedge clka);
        #1;
        if (!rsp_auto) begin
            rsp_ph   = 0;
            ack_auto = 1'b0;
        end else if (sync_pulse_o) begin
            rsp_ph   = 1;
            rsp_cnt  = 0;
            ack_auto = 1'b0;
            cur_hi   = rsp_rand ? int'($urandom_range(1, 6)) : hi_dly;
            cur_lo   = rsp_rand ? int'($urandom_range(1, 6)) : lo_dly;
        end else if (rsp_ph == 1) begin
            rsp_cnt++;
            if (rsp_cnt == cur_hi) begin
                ack_auto = 1'b1;
                rsp_ph   = 2;
                rsp_cnt  = 0;
            end
        end else if (rsp_ph == 2) begin
            rsp_cnt++;
            if (rsp_cnt == cur_lo) begin
                ack_auto = 1'b0;
                rsp_ph   = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clka);
            #1;
        end
    endtask

    // Drives v for exactly one edge; e returns the index of that edge.
    task automatic pulse_req(input logic [N-1:0] v, output int e);
        req_i = v;
        step(1);
        req_i = '0;
        e = cyc;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        rsp_auto = 1'b0;
        rsp_rand = 1'b0;
        ack_man  = 1'b0;
        req_i    = '0;
        step(3);
        rst = 1'b0;
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        int k;
        for (int i = 0; i < N; i++) begin
            k = (p + i) % N;
            if (v[k[IW-1:0]]) return k;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst = 1'b1; req_i = '1; rsp_auto = 1'b0; ack_man = 1'b0;
        step(3);
        n_chk++; if (sync_pulse_o !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %b expected 0", sync_pulse_o); end
        n_chk++; if (sync_id_o !== '0) begin n_fail++; $display("FAIL reset_id: got %0d expected 0", sync_id_o); end
        n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        n_chk++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b expected 0", timeout_o); end
        n_chk++; if (ovf_o !== '0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0000", ovf_o); end
        n_chk++; if (pend_o !== '0) begin n_fail++; $display("FAIL reset_pend: got %b expected 0000", pend_o); end
        req_i = '0;
        rst   = 1'b0;
    endtask

    task automatic test_single_event();
        int e0, n_p, bad;
        do_reset();
        hi_dly = 6; lo_dly = 6; rsp_auto = 1'b1;
        step(2);
        pulse_req(4'b0100, e0);
        step(20);
        n_chk++; if (pend_log[e0] !== 4'b0100) begin n_fail++; $display("FAIL single_pend_set: got %b expected 0100", pend_log[e0]); end
        n_chk++; if (pulse_log[e0+1] !== 1'b1) begin n_fail++; $display("FAIL single_latency: pulse after req edge+1 got %b expected 1", pulse_log[e0+1]); end
        n_chk++; if (id_log[e0+1] !== 2'd2) begin n_fail++; $display("FAIL single_id: got %0d expected 2", id_log[e0+1]); end
        n_p = 0;
        for (int c = e0 - 1; c <= e0 + 19; c++) n_p += int'(pulse_log[c] === 1'b1);
        n_chk++; if (n_p != 1) begin n_fail++; $display("FAIL single_pulse_count: got %0d expected 1", n_p); end
        // Busy from the issue edge until the edge that sees ack low again: hi+lo+1 cycles.
        bad = -1;
        for (int c = e0; c <= e0 + 19; c++)
            if (bad < 0 && busy_log[c] !== ((c >= e0 + 1) && (c <= e0 + 1 + hi_dly + lo_dly))) bad = c - e0;
        n_chk++; if (bad != -1) begin n_fail++; $display("FAIL single_busy: first wrong busy at req+%0d, got %b expected none", bad, busy_log[e0+bad]); end
        n_chk++; if (sync_id_o !== 2'd2) begin n_fail++; $display("FAIL single_id_held: got %0d expected 2", sync_id_o); end
    endtask

    task automatic test_fairness();
        int e0, e1;
        int q[$];
        do_reset();
        hi_dly = 5; lo_dly = 5; rsp_auto = 1'b1;
        step(2);
        pulse_req(4'b1111, e0);
        step(60);
        for (int c = e0; c <= e0 + 59; c++) if (pulse_log[c] === 1'b1) q.push_back(c);
        n_chk++; if (q.size() != 4) begin n_fail++; $display("FAIL fair_count: got %0d issues expected 4", q.size()); end
        for (int k = 0; k < q.size() && k < 4; k++) begin
            n_chk++; if (id_log[q[k]] !== IW'(k)) begin n_fail++; $display("FAIL fair_order[%0d]: got %0d expected %0d", k, id_log[q[k]], k); end
            if (k > 0) begin
                n_chk++; if (q[k] - q[k-1] != hi_dly + lo_dly + 2) begin n_fail++; $display("FAIL fair_interval[%0d]: got %0d expected %0d", k, q[k] - q[k-1], hi_dly + lo_dly + 2); end
            end
        end
        pulse_req(4'b1111, e1);
        step(4);
        n_chk++; if (pulse_log[e1+1] !== 1'b1) begin n_fail++; $display("FAIL fair_wrap_issue: got %b expected 1", pulse_log[e1+1]); end
        n_chk++; if (id_log[e1+1] !== 2'd0) begin n_fail++; $display("FAIL fair_wrap_id: got %0d expected 0", id_log[e1+1]); end
    endtask

    task automatic test_overflow();
        int e0, ea, eb, n1, nx;
        int q[$];
        do_reset();
        hi_dly = 6; lo_dly = 6; rsp_auto = 1'b1;
        step(2);
        pulse_req(4'b0011, e0);
        step(2);
        pulse_req(4'b0010, ea);
        step(1);
        pulse_req(4'b0010, eb);
        step(26);
        n_chk++; if (ovf_log[ea] !== 4'b0010) begin n_fail++; $display("FAIL ovf_first: got %b expected 0010", ovf_log[ea]); end
        n_chk++; if (ovf_log[eb] !== 4'b0010) begin n_fail++; $display("FAIL ovf_second: got %b expected 0010", ovf_log[eb]); end
        n1 = 0; nx = 0;
        for (int c = e0; c <= e0 + 30; c++) begin
            n1 += int'(ovf_log[c][1] === 1'b1);
            nx += int'((ovf_log[c] & 4'b1101) !== 4'b0000);
            if (pulse_log[c] === 1'b1) q.push_back(int'(id_log[c]));
        end
        n_chk++; if (n1 != 2) begin n_fail++; $display("FAIL ovf_count: got %0d expected 2", n1); end
        n_chk++; if (nx != 0) begin n_fail++; $display("FAIL ovf_other_bits: got %0d cycles expected 0", nx); end
        n_chk++; if (q.size() != 2) begin n_fail++; $display("FAIL ovf_issue_count: got %0d expected 2", q.size()); end
        if (q.size() == 2) begin
            n_chk++; if (q[0] != 0 || q[1] != 1) begin n_fail++; $display("FAIL ovf_issue_ids: got %0d,%0d expected 0,1", q[0], q[1]); end
        end
    endtask

    task automatic test_same_edge();
        int e0, e, nxt;
        do_reset();
        hi_dly = 4; lo_dly = 4; rsp_auto = 1'b1;
        step(2);
        pulse_req(4'b1001, e0);
        // ID 0 issues at e0+1, so ID 3 issues one handshake plus one idle cycle later.
        step(hi_dly + lo_dly + 2);
        pulse_req(4'b1000, e);
        step(20);
        n_chk++; if (pulse_log[e] !== 1'b1 || id_log[e] !== 2'd3) begin n_fail++; $display("FAIL same_grant: got pulse %b id %0d expected pulse 1 id 3", pulse_log[e], id_log[e]); end
        n_chk++; if (pend_log[e][3] !== 1'b1) begin n_fail++; $display("FAIL same_pend_kept: got %b expected 1", pend_log[e][3]); end
        n_chk++; if (ovf_log[e][3] !== 1'b0) begin n_fail++; $display("FAIL same_no_ovf: got %b expected 0", ovf_log[e][3]); end
        nxt = -1;
        for (int c = e + 1; c <= e + 19; c++) if (nxt < 0 && pulse_log[c] === 1'b1) nxt = c;
        n_chk++; if (nxt != e + hi_dly + lo_dly + 2) begin n_fail++; $display("FAIL same_reissue_cyc: got offset %0d expected %0d", nxt - e, hi_dly + lo_dly + 2); end
        n_chk++; if (nxt < 0 || id_log[nxt] !== 2'd3) begin n_fail++; $display("FAIL same_reissue_id: got %0d expected 3", (nxt < 0) ? -1 : int'(id_log[nxt])); end
    endtask

    task automatic test_timeout();
        int e0, t1, nt;
        do_reset();
        hi_dly = 0; lo_dly = 1; rsp_auto = 1'b1;
        step(2);
        pulse_req(4'b0011, e0);
        step(40);
        t1 = -1; nt = 0;
        for (int c = e0; c <= e0 + 39; c++) begin
            if (to_log[c] === 1'b1) begin
                nt++;
                if (t1 < 0) t1 = c;
            end
        end
        n_chk++; if (t1 != e0 + 1 + TO) begin n_fail++; $display("FAIL to_first: got issue+%0d expected issue+%0d", t1 - e0 - 1, TO); end
        n_chk++; if (busy_log[e0+1+TO] !== 1'b0) begin n_fail++; $display("FAIL to_idle: got busy %b expected 0", busy_log[e0+1+TO]); end
        n_chk++; if (pend_log[e0+1+TO] !== 4'b0010) begin n_fail++; $display("FAIL to_dropped: got pend %b expected 0010", pend_log[e0+1+TO]); end
        n_chk++; if (pulse_log[e0+2+TO] !== 1'b1 || id_log[e0+2+TO] !== 2'd1) begin n_fail++; $display("FAIL to_next_issue: got pulse %b id %0d expected pulse 1 id 1", pulse_log[e0+2+TO], id_log[e0+2+TO]); end
        n_chk++; if (nt != 2) begin n_fail++; $display("FAIL to_count: got %0d expected 2", nt); end
    endtask

    task automatic test_reset_mid();
        int e0, ex, e1, r, a, n_p, n_t;
        do_reset();
        step(2);
        pulse_req(4'b0100, e0);
        step(2);
        ack_man = 1'b1;
        step(3);
        n_chk++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before: got %b expected 1", busy_o); end
        pulse_req(4'b0001, ex);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        r = cyc;
        n_chk++; if (sync_pulse_o !== 1'b0 || busy_o !== 1'b0 || timeout_o !== 1'b0) begin n_fail++; $display("FAIL rmid_ctrl: got pulse %b busy %b timeout %b expected 0 0 0", sync_pulse_o, busy_o, timeout_o); end
        n_chk++; if (sync_id_o !== '0 || pend_o !== '0 || ovf_o !== '0) begin n_fail++; $display("FAIL rmid_data: got id %0d pend %b ovf %b expected 0 0000 0000", sync_id_o, pend_o, ovf_o); end
        pulse_req(4'b1010, e1);
        step(6);
        a = cyc;
        n_p = 0; n_t = 0;
        for (int c = r; c < a; c++) n_p += int'(pulse_log[c] === 1'b1);
        for (int c = e0; c < a; c++) n_t += int'(to_log[c] === 1'b1);
        n_chk++; if (n_p != 0) begin n_fail++; $display("FAIL rmid_stale_ack: got %0d issues expected 0", n_p); end
        n_chk++; if (n_t != 0) begin n_fail++; $display("FAIL rmid_no_timeout: got %0d expected 0", n_t); end
        ack_man = 1'b0;
        step(4);
        n_chk++; if (pulse_log[a+1] !== 1'b1 || id_log[a+1] !== 2'd1) begin n_fail++; $display("FAIL rmid_issue: got pulse %b id %0d expected pulse 1 id 1", pulse_log[a+1], id_log[a+1]); end
    endtask

    // Reference: the pending set with a rotating pointer, advanced by the spec rules each edge.
    task automatic test_random();
        int s, last, waited, w, mptr, nerr;
        logic [N-1:0] mp, clr, eo;
        logic go;
        do_reset();
        rsp_rand = 1'b1; rsp_auto = 1'b1;
        s = cyc;
        for (int i = 0; i < 300; i++) begin
            req_i = N'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
            step(1);
        end
        req_i = '0;
        waited = 0;
        while ((busy_o || pend_o != '0) && waited < 300) begin
            step(1);
            waited++;
        end
        n_chk++; if (waited >= 300) begin n_fail++; $display("FAIL rand_drain: got busy %b pend %b after %0d cycles expected idle", busy_o, pend_o, waited); end
        step(2);
        last = cyc - 1;
        mp = '0; mptr = 0; nerr = 0;
        for (int c = s + 1; c <= last && nerr < 10; c++) begin
            go  = !busy_log[c-1] && (mp != '0) && !ack_log[c];
            clr = '0;
            n_chk++; if (pulse_log[c] !== go) begin n_fail++; nerr++; $display("FAIL rand_issue@%0d: got %b expected %b", c, pulse_log[c], go); end
            if (go) begin
                w = rr_pick(mp, mptr);
                n_chk++; if (id_log[c] !== IW'(w)) begin n_fail++; nerr++; $display("FAIL rand_id@%0d: got %0d expected %0d", c, id_log[c], w); end
                clr[w[IW-1:0]] = 1'b1;
                mptr = (w + 1) % N;
            end
            eo = req_log[c] & mp & ~clr;
            n_chk++; if (ovf_log[c] !== eo) begin n_fail++; nerr++; $display("FAIL rand_ovf@%0d: got %b expected %b", c, ovf_log[c], eo); end
            mp = (mp & ~clr) | req_log[c];
            n_chk++; if (pend_log[c] !== mp) begin n_fail++; nerr++; $display("FAIL rand_pend@%0d: got %b expected %b", c, pend_log[c], mp); end
        end
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_fairness();
        test_overflow();
        test_same_edge();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
